side_aggregator: RTL and testbench

SIDE_AGGREGATOR -- requirements
Module: side_aggregator

---
 rtl/pb_book_pkg.sv | 33 +++
 rtl/level_table.sv | 75 +++++++
 rtl/side_aggregator.sv | 134 +++++++++++++
 tb/tb_side_aggregator.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pb_book_pkg.sv
// Shared order-book definitions: opcodes, side encoding, level-slot layout and FSM states.
// Slot fields are sized to a 64-bit ceiling so any PRICE_W/QTY_W up to 64 fits.
package pb_book_pkg;

   localparam int PB_MAX_PRICE_W = 64;
   localparam int PB_MAX_QTY_W   = 64;

   localparam logic [2:0] OP_NOP     = 3'd0;
   localparam logic [2:0] OP_ADD     = 3'd1;
   localparam logic [2:0] OP_CANCEL  = 3'd2;
   localparam logic [2:0] OP_DELETE  = 3'd3;
   localparam logic [2:0] OP_EXECUTE = 3'd4;

   localparam logic SIDE_BID = 1'b0;
   localparam logic SIDE_ASK = 1'b1;

   typedef struct packed {
      logic                      valid;
      logic [PB_MAX_PRICE_W-1:0] price;
      logic [PB_MAX_QTY_W-1:0]   qty;
   } level_slot_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_APPLY = 2'd1,
      ST_BEST  = 2'd2
   } agg_state_t;

   function automatic logic is_book_op(input logic [2:0] code);
      return (code >= OP_ADD) && (code <= OP_EXECUTE);
   endfunction

endpackage

// File: rtl/level_table.sv
// One side of the book: price-level slots, price match / free-slot search and best-price reduction.
// IS_ASK selects the reduction direction (min price for asks, max price for bids).
module level_table
   import pb_book_pkg::*;
#(
   parameter int PRICE_W = 48,
   parameter int QTY_W   = 32,
   parameter int LEVELS  = 32,
   parameter bit IS_ASK  = 1'b0,
   localparam int IDX_W  = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PRICE_W-1:0] lk_price,
   output logic               hit,
   output logic [IDX_W-1:0]   hit_idx,
   output logic [QTY_W-1:0]   hit_qty,
   output logic               free_v,
   output logic [IDX_W-1:0]   free_idx,
   input  logic               wr_en,
   input  logic [IDX_W-1:0]   wr_idx,
   input  logic [QTY_W-1:0]   wr_qty,
   output logic               best_v,
   output logic [PRICE_W-1:0] best_price
);

   level_slot_t               slots [LEVELS];
   logic [PB_MAX_PRICE_W-1:0] best_full;

   // Writing a zero quantity retires the slot; the write price is always the lookup price.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LEVELS; i++) slots[i] <= '0;
      end else if (wr_en) begin
         slots[wr_idx].valid <= (wr_qty != '0);
         slots[wr_idx].price <= PB_MAX_PRICE_W'(lk_price);
         slots[wr_idx].qty   <= PB_MAX_QTY_W'(wr_qty);
      end
   end

   // Descending scan so the lowest-index free slot is the one left standing.
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      hit_qty  = '0;
      free_v   = 1'b0;
      free_idx = '0;
      for (int i = LEVELS - 1; i >= 0; i--) begin
         if (slots[i].valid && (slots[i].price == PB_MAX_PRICE_W'(lk_price))) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
            hit_qty = QTY_W'(slots[i].qty);
         end
         if (!slots[i].valid) begin
            free_v   = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      best_v    = 1'b0;
      best_full = '0;
      for (int i = 0; i < LEVELS; i++) begin
         if (slots[i].valid && (!best_v ||
             (IS_ASK ? (slots[i].price < best_full) : (slots[i].price > best_full)))) begin
            best_v    = 1'b1;
            best_full = slots[i].price;
         end
      end
   end

   assign best_price = PRICE_W'(best_full);

endmodule

// File: rtl/side_aggregator.sv
// Price-level aggregator: IDLE/APPLY/BEST FSM applying book ops to per-side level tables.
// Define SIDE_AGGREGATOR_STATS_EN to add the op_cnt/drop_cnt counter outputs.
module side_aggregator
   import pb_book_pkg::*;
#(
   parameter int PRICE_W = 48,
   parameter int QTY_W   = 32,
   parameter int LEVELS  = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_v,
   output logic               in_r,
   input  logic               in_valid,
   input  logic [2:0]         in_opcode,
   input  logic               in_side,
   input  logic [PRICE_W-1:0] in_price,
   input  logic [QTY_W-1:0]   in_qty,
   output logic               tap_v,
   output logic               tap_side,
   output logic [PRICE_W-1:0] tap_price,
   output logic [QTY_W-1:0]   tap_newqty,
   output logic               best_bid_v,
   output logic [PRICE_W-1:0] best_bid_price,
   output logic               best_ask_v,
   output logic [PRICE_W-1:0] best_ask_price,
   output logic               drop_v,
   output logic [1:0]         state_dbg
`ifdef SIDE_AGGREGATOR_STATS_EN
   ,
   output logic [31:0]        op_cnt,
   output logic [31:0]        drop_cnt
`endif
);

   localparam int IDX_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;

   agg_state_t         state;
   logic               op_side;
   logic [2:0]         op_code;
   logic [PRICE_W-1:0] op_price;
   logic [QTY_W-1:0]   op_qty;

   logic               b_hit, a_hit, b_free, a_free, b_best_v, a_best_v;
   logic [IDX_W-1:0]   b_hit_idx, a_hit_idx, b_free_idx, a_free_idx, wr_idx;
   logic [QTY_W-1:0]   b_hit_qty, a_hit_qty, old_qty, newqty;
   logic [PRICE_W-1:0] b_best_p, a_best_p;
   logic [QTY_W:0]     sum;
   logic               old_hit, free_v, is_add, drop, wr_en, accept;

   // Handshake: a beat transfers on a clock edge where in_v && in_r; in_r is high only in IDLE.
   // A transferred beat with in_valid=0 or opcode outside 1-4 is consumed as a NOP.
   assign in_r   = (state == ST_IDLE);
   assign accept = in_v && in_r && in_valid && is_book_op(in_opcode);
   assign is_add = (op_code == OP_ADD);

   always_comb begin
      old_hit = op_side ? a_hit      : b_hit;
      old_qty = op_side ? a_hit_qty  : b_hit_qty;
      free_v  = op_side ? a_free     : b_free;
      sum     = {1'b0, old_qty} + {1'b0, op_qty};
      if (is_add) newqty = old_hit ? (sum[QTY_W] ? '1 : sum[QTY_W-1:0]) : op_qty;
      else        newqty = (old_hit && (old_qty > op_qty)) ? (old_qty - op_qty) : '0;
      // A zero-quantity ADD never allocates, so it taps zero even on a full side.
      drop    = is_add && !old_hit && !free_v && (op_qty != '0);
      wr_en   = (state == ST_APPLY) && (old_hit || (is_add && free_v && (op_qty != '0)));
      wr_idx  = old_hit ? (op_side ? a_hit_idx : b_hit_idx) : (op_side ? a_free_idx : b_free_idx);
   end

   assign tap_v      = (state == ST_APPLY) && !drop;
   assign drop_v     = (state == ST_APPLY) && drop;
   assign tap_side   = op_side;
   assign tap_price  = op_price;
   assign tap_newqty = newqty;
   assign state_dbg  = state;

   level_table #(.PRICE_W(PRICE_W), .QTY_W(QTY_W), .LEVELS(LEVELS), .IS_ASK(1'b0)) u_bid (
      .clk(clk), .rst(rst), .lk_price(op_price),
      .hit(b_hit), .hit_idx(b_hit_idx), .hit_qty(b_hit_qty),
      .free_v(b_free), .free_idx(b_free_idx),
      .wr_en(wr_en && (op_side == SIDE_BID)), .wr_idx(wr_idx), .wr_qty(newqty),
      .best_v(b_best_v), .best_price(b_best_p)
   );

   level_table #(.PRICE_W(PRICE_W), .QTY_W(QTY_W), .LEVELS(LEVELS), .IS_ASK(1'b1)) u_ask (
      .clk(clk), .rst(rst), .lk_price(op_price),
      .hit(a_hit), .hit_idx(a_hit_idx), .hit_qty(a_hit_qty),
      .free_v(a_free), .free_idx(a_free_idx),
      .wr_en(wr_en && (op_side == SIDE_ASK)), .wr_idx(wr_idx), .wr_qty(newqty),
      .best_v(a_best_v), .best_price(a_best_p)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_IDLE;
         op_side        <= 1'b0;
         op_code        <= OP_NOP;
         op_price       <= '0;
         op_qty         <= '0;
         best_bid_v     <= 1'b0;
         best_bid_price <= '0;
         best_ask_v     <= 1'b0;
         best_ask_price <= '0;
`ifdef SIDE_AGGREGATOR_STATS_EN
         op_cnt         <= '0;
         drop_cnt       <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: if (accept) begin
               op_side  <= in_side;
               op_code  <= in_opcode;
               op_price <= in_price;
               op_qty   <= in_qty;
               state    <= ST_APPLY;
            end
            ST_APPLY: state <= ST_BEST;
            ST_BEST: begin
               best_bid_v     <= b_best_v;
               best_bid_price <= b_best_p;
               best_ask_v     <= a_best_v;
               best_ask_price <= a_best_p;
               state          <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
`ifdef SIDE_AGGREGATOR_STATS_EN
         if (accept) op_cnt   <= op_cnt + 32'd1;
         if (drop_v) drop_cnt <= drop_cnt + 32'd1;
`endif
      end
   end

endmodule

// File: tb/tb_side_aggregator.sv
// Directed bench for side_aggregator: hand-computed taps, drops and top-of-book per step.
module tb_side_aggregator;
   import pb_book_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_v = 1'b0, in_valid = 1'b0, in_side = 1'b0;
   logic [2:0]  in_opcode = 3'd0;
   logic [47:0] in_price = '0;
   logic [31:0] in_qty = '0;
   logic        in_r, tap_v, tap_side, best_bid_v, best_ask_v, drop_v;
   logic [47:0] tap_price, best_bid_price, best_ask_price;
   logic [31:0] tap_newqty;
   logic [1:0]  state_dbg;
`ifdef SIDE_AGGREGATOR_STATS_EN
   logic [31:0] op_cnt, drop_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int n_ops = 0;
   int n_drops = 0;

   always #5 clk = ~clk;

   side_aggregator #(.PRICE_W(48), .QTY_W(32), .LEVELS(32)) dut (
      .clk(clk), .rst(rst),
      .in_v(in_v), .in_r(in_r), .in_valid(in_valid), .in_opcode(in_opcode),
      .in_side(in_side), .in_price(in_price), .in_qty(in_qty),
      .tap_v(tap_v), .tap_side(tap_side), .tap_price(tap_price), .tap_newqty(tap_newqty),
      .best_bid_v(best_bid_v), .best_bid_price(best_bid_price),
      .best_ask_v(best_ask_v), .best_ask_price(best_ask_price),
      .drop_v(drop_v), .state_dbg(state_dbg)
`ifdef SIDE_AGGREGATOR_STATS_EN
      , .op_cnt(op_cnt), .drop_cnt(drop_cnt)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one valid op; returns #1 after the accepting edge (DUT in APPLY).
   task automatic op(input logic [2:0] code, input logic side, input logic [47:0] price,
                     input logic [31:0] qty);
      int n = 0;
      @(negedge clk);
      while (!in_r && n < 8) begin
         @(negedge clk);
         n++;
      end
      check("in_r_wait", 64'(in_r), 64'(1));
      in_v = 1'b1; in_valid = 1'b1; in_opcode = code;
      in_side = side; in_price = price; in_qty = qty;
      @(posedge clk); #1;
      in_v = 1'b0; in_valid = 1'b0;
      n_ops++;
   endtask

   task automatic run(input logic [2:0] code, input logic side, input logic [47:0] price,
                      input logic [31:0] qty, input logic exp_drop, input logic [31:0] exp_qty);
      op(code, side, price, qty);
      check("apply_state", 64'(state_dbg), 64'(ST_APPLY));
      check("tap_v", 64'(tap_v), 64'(!exp_drop));
      check("drop_v", 64'(drop_v), 64'(exp_drop));
      if (exp_drop) n_drops++;
      else begin
         check("tap_side", 64'(tap_side), 64'(side));
         check("tap_price", 64'(tap_price), 64'(price));
         check("tap_newqty", 64'(tap_newqty), 64'(exp_qty));
      end
      @(posedge clk); #1;
      check("best_no_tap", 64'(tap_v), 64'(0));
      check("best_no_drop", 64'(drop_v), 64'(0));
      check("best_in_r_low", 64'(in_r), 64'(0));
      @(posedge clk); #1;
      check("idle_in_r", 64'(in_r), 64'(1));
   endtask

   task automatic best(input logic bv, input logic [47:0] bp, input logic av, input logic [47:0] ap);
      check("best_bid_v", 64'(best_bid_v), 64'(bv));
      check("best_bid_price", 64'(best_bid_price), 64'(bp));
      check("best_ask_v", 64'(best_ask_v), 64'(av));
      check("best_ask_price", 64'(best_ask_price), 64'(ap));
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
      check("rst_in_r", 64'(in_r), 64'(1));
      check("rst_tap_v", 64'(tap_v), 64'(0));
      check("rst_drop_v", 64'(drop_v), 64'(0));
      check("rst_tap_price", 64'(tap_price), 64'(0));
      best(1'b0, 48'd0, 1'b0, 48'd0);
      @(negedge clk); rst = 1'b0; #1;
      check("rel_in_r", 64'(in_r), 64'(1));

      // Bid accumulation at one level
      run(OP_ADD, SIDE_BID, 48'd100, 32'd5, 1'b0, 32'd5);
      best(1'b1, 48'd100, 1'b0, 48'd0);
      run(OP_ADD, SIDE_BID, 48'd100, 32'd3, 1'b0, 32'd8);
      best(1'b1, 48'd100, 1'b0, 48'd0);

      // Ask executions down to empty
      run(OP_ADD, SIDE_ASK, 48'd105, 32'd10, 1'b0, 32'd10);
      best(1'b1, 48'd100, 1'b1, 48'd105);
      run(OP_EXECUTE, SIDE_ASK, 48'd105, 32'd4, 1'b0, 32'd6);
      run(OP_EXECUTE, SIDE_ASK, 48'd105, 32'd9, 1'b0, 32'd0);
      best(1'b1, 48'd100, 1'b0, 48'd0);

      // Ask side reports the minimum price
      run(OP_ADD, SIDE_ASK, 48'd120, 32'd1, 1'b0, 32'd1);
      best(1'b1, 48'd100, 1'b1, 48'd120);
      run(OP_ADD, SIDE_ASK, 48'd110, 32'd2, 1'b0, 32'd2);
      run(OP_ADD, SIDE_ASK, 48'd115, 32'd1, 1'b0, 32'd1);
      best(1'b1, 48'd100, 1'b1, 48'd110);

      // NOP beats: in_valid=0 and opcode 5 are consumed without leaving IDLE
      @(negedge clk);
      in_v = 1'b1; in_valid = 1'b0; in_opcode = OP_ADD; in_side = SIDE_BID;
      in_price = 48'd100; in_qty = 32'd1;
      @(posedge clk); #1;
      check("nop_invalid_state", 64'(state_dbg), 64'(ST_IDLE));
      check("nop_invalid_tap", 64'(tap_v), 64'(0));
      @(negedge clk);
      in_valid = 1'b1; in_opcode = 3'd5;
      @(posedge clk); #1;
      check("nop_op5_state", 64'(state_dbg), 64'(ST_IDLE));
      check("nop_op5_in_r", 64'(in_r), 64'(1));
      in_v = 1'b0; in_valid = 1'b0;
      run(OP_CANCEL, SIDE_BID, 48'd100, 32'd0, 1'b0, 32'd8);

      // Clamp at zero, then cancel on an empty side
      run(OP_DELETE, SIDE_BID, 48'd100, 32'd20, 1'b0, 32'd0);
      best(1'b0, 48'd0, 1'b1, 48'd110);
      run(OP_CANCEL, SIDE_BID, 48'd77, 32'd3, 1'b0, 32'd0);
      best(1'b0, 48'd0, 1'b1, 48'd110);
      run(OP_ADD, SIDE_BID, 48'd77, 32'd2, 1'b0, 32'd2);
      best(1'b1, 48'd77, 1'b1, 48'd110);
      run(OP_ADD, SIDE_BID, 48'd60, 32'd0, 1'b0, 32'd0);
      best(1'b1, 48'd77, 1'b1, 48'd110);

      // Saturating add
      run(OP_ADD, SIDE_BID, 48'd90, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF);
      run(OP_ADD, SIDE_BID, 48'd90, 32'd1, 1'b0, 32'hFFFF_FFFF);
      best(1'b1, 48'd90, 1'b1, 48'd110);
      run(OP_DELETE, SIDE_BID, 48'd90, 32'hFFFF_FFFF, 1'b0, 32'd0);
      run(OP_DELETE, SIDE_BID, 48'd77, 32'd2, 1'b0, 32'd0);
      best(1'b0, 48'd0, 1'b1, 48'd110);

      // Fill every bid slot, then overflow
      for (int p = 1; p <= 32; p++) begin
         run(OP_ADD, SIDE_BID, 48'(p), 32'd1, 1'b0, 32'd1);
         check("fill_best", 64'(best_bid_price), 64'(p));
      end
      run(OP_ADD, SIDE_BID, 48'd50, 32'd7, 1'b1, 32'd0);
      best(1'b1, 48'd32, 1'b1, 48'd110);
      run(OP_ADD, SIDE_BID, 48'd5, 32'd2, 1'b0, 32'd3);
      run(OP_EXECUTE, SIDE_BID, 48'd32, 32'd1, 1'b0, 32'd0);
      best(1'b1, 48'd31, 1'b1, 48'd110);
      run(OP_ADD, SIDE_BID, 48'd50, 32'd7, 1'b0, 32'd7);
      best(1'b1, 48'd50, 1'b1, 48'd110);

`ifdef SIDE_AGGREGATOR_STATS_EN
      check("op_cnt", 64'(op_cnt), 64'(n_ops));
      check("drop_cnt", 64'(drop_cnt), 64'(n_drops));
`endif

      // Reset during APPLY loses the op
      op(OP_ADD, SIDE_ASK, 48'd200, 32'd4);
      check("r_mid_state", 64'(state_dbg), 64'(ST_APPLY));
      rst = 1'b1; #1;
      check("r_mid_tap", 64'(tap_v), 64'(0));
      check("r_mid_idle", 64'(state_dbg), 64'(ST_IDLE));
      best(1'b0, 48'd0, 1'b0, 48'd0);
      @(negedge clk); rst = 1'b0; #1;
      n_ops = 0; n_drops = 0;
      check("r_rel_in_r", 64'(in_r), 64'(1));
      @(posedge clk); #1;
      check("r_rel_tap", 64'(tap_v), 64'(0));
      check("r_rel_idle", 64'(state_dbg), 64'(ST_IDLE));
      best(1'b0, 48'd0, 1'b0, 48'd0);
      run(OP_ADD, SIDE_ASK, 48'd200, 32'd4, 1'b0, 32'd4);
      best(1'b0, 48'd0, 1'b1, 48'd200);
      run(OP_ADD, SIDE_BID, 48'd5, 32'd1, 1'b0, 32'd1);
      best(1'b1, 48'd5, 1'b1, 48'd200);
`ifdef SIDE_AGGREGATOR_STATS_EN
      check("op_cnt_after_rst", 64'(op_cnt), 64'(n_ops));
      check("drop_cnt_after_rst", 64'(drop_cnt), 64'(n_drops));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
